// File: rtl/demux_1x2.sv
// demux_1x2: routes one data word to either o1 or o2 under the select line.
// The unselected channel is always driven to zero, so a consumer never sees
// stale data. Outputs are registered behind an async active-low reset when
// REGISTERED is nonzero, otherwise the steering is purely combinational.
module demux_1x2 #(
  parameter int WIDTH      = 1,
  parameter int REGISTERED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] i,
  input  logic             s,
  input  logic             v,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic             o1_v,
  output logic             o2_v
);

  logic [WIDTH-1:0] o1_d;
  logic [WIDTH-1:0] o2_d;
  logic             o1_v_d;
  logic             o2_v_d;

  // Steering: everything defaults to zero, only the selected channel follows i/v.
  always_comb begin
    o1_d   = '0;
    o2_d   = '0;
    o1_v_d = 1'b0;
    o2_v_d = 1'b0;
    if (en) begin
      if (s) begin
        o2_d   = i;
        o2_v_d = v;
      end else begin
        o1_d   = i;
        o1_v_d = v;
      end
    end
  end

  generate
    if (REGISTERED != 0) begin : genReg
      logic [WIDTH-1:0] o1_q;
      logic [WIDTH-1:0] o2_q;
      logic             o1_v_q;
      logic             o2_v_q;

      // Output register; reset clears both channels at once and drops any in-flight word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o1_q   <= '0;
          o2_q   <= '0;
          o1_v_q <= 1'b0;
          o2_v_q <= 1'b0;
        end else begin
          o1_q   <= o1_d;
          o2_q   <= o2_d;
          o1_v_q <= o1_v_d;
          o2_v_q <= o2_v_d;
        end
      end

      assign o1   = o1_q;
      assign o2   = o2_q;
      assign o1_v = o1_v_q;
      assign o2_v = o2_v_q;
    end else begin : genComb
      // Clock and reset have no role in the combinational variant.
      logic unusedClkRst;
      assign unusedClkRst = clk ^ rst_n;

      assign o1   = o1_d;
      assign o2   = o2_d;
      assign o1_v = o1_v_d;
      assign o2_v = o2_v_d;
    end
  endgenerate

endmodule

// File: tb/tb_demux_1x2.sv
// tb_demux_1x2: exercises a combinational 1-bit instance, a registered 8-bit
// instance (directed cases) and a registered 16-bit instance (random traffic)
// against a behavioural steering model.
module tb_demux_1x2;

  typedef struct packed {
    logic [63:0] o1;
    logic [63:0] o2;
    logic        o1v;
    logic        o2v;
  } outs_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // shared controls for the registered instances
  logic en = 1'b0;
  logic s  = 1'b0;
  logic v  = 1'b0;
  logic [7:0]  i8  = '0;
  logic [15:0] i16 = '0;

  logic [7:0]  r8O1, r8O2;
  logic        r8O1v, r8O2v;
  logic [15:0] r16O1, r16O2;
  logic        r16O1v, r16O2v;

  // combinational instance controls
  logic cEn = 1'b0;
  logic cS  = 1'b0;
  logic cV  = 1'b0;
  logic cI  = 1'b0;
  logic cO1, cO2, cO1v, cO2v;

  always #5 clk = ~clk;

  demux_1x2 #(.WIDTH(1), .REGISTERED(0)) dutComb (
    .clk(clk), .rst_n(rst_n), .en(cEn), .i(cI), .s(cS), .v(cV),
    .o1(cO1), .o2(cO2), .o1_v(cO1v), .o2_v(cO2v)
  );

  demux_1x2 #(.WIDTH(8), .REGISTERED(1)) dutReg8 (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i8), .s(s), .v(v),
    .o1(r8O1), .o2(r8O2), .o1_v(r8O1v), .o2_v(r8O2v)
  );

  demux_1x2 #(.WIDTH(16), .REGISTERED(1)) dutReg16 (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i16), .s(s), .v(v),
    .o1(r16O1), .o2(r16O2), .o1_v(r16O1v), .o2_v(r16O2v)
  );

  // Reference: what the steering rules say the four outputs should be.
  function automatic outs_t steer(input logic e, input logic sel,
                                  input logic val, input logic [63:0] d);
    outs_t r;
    r = '0;
    if (e) begin
      if (sel) begin r.o2 = d; r.o2v = val; end
      else     begin r.o1 = d; r.o1v = val; end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input outs_t got, input outs_t exp);
    checkOutput({tag, ".o1"},   got.o1,  exp.o1);
    checkOutput({tag, ".o2"},   got.o2,  exp.o2);
    checkOutput({tag, ".o1_v"}, 64'(got.o1v), 64'(exp.o1v));
    checkOutput({tag, ".o2_v"}, 64'(got.o2v), 64'(exp.o2v));
    checkOutput({tag, ".excl"}, 64'(got.o1v & got.o2v), 64'd0);
  endtask

  function automatic outs_t got8();
    outs_t r;
    r.o1 = 64'(r8O1); r.o2 = 64'(r8O2); r.o1v = r8O1v; r.o2v = r8O2v;
    return r;
  endfunction

  function automatic outs_t got16();
    outs_t r;
    r.o1 = 64'(r16O1); r.o2 = 64'(r16O2); r.o1v = r16O1v; r.o2v = r16O2v;
    return r;
  endfunction

  function automatic outs_t gotComb();
    outs_t r;
    r.o1 = 64'(cO1); r.o2 = 64'(cO2); r.o1v = cO1v; r.o2v = cO2v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic sel, input logic val,
                               input logic [7:0] d8);
    en = e; s = sel; v = val; i8 = d8;
  endtask

  // combinational table: s, i -> expected o1, o2
  logic [3:0] combTab [4] = '{4'b0_1_10, 4'b1_1_01, 4'b0_0_00, 4'b1_0_00};

  initial begin
    outs_t zero, exp;
    logic [3:0] row;
    zero = '0;

    // reset state, async with no clock edge yet
    #2;
    checkAll("rst8", got8(), zero);
    checkAll("rst16", got16(), zero);

    // combinational instance, 5 ns steps
    cEn = 1'b1; cV = 1'b1;
    for (int k = 0; k < 4; k++) begin
      row = combTab[k];
      cS = row[3]; cI = row[2];
      #5;
      checkOutput($sformatf("comb%0d.o1", k), 64'(cO1), 64'(row[1]));
      checkOutput($sformatf("comb%0d.o2", k), 64'(cO2), 64'(row[0]));
    end

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5);
    tick();
    exp = '0; exp.o1 = 64'hA5; exp.o1v = 1'b1;
    checkAll("a5_o1", got8(), exp);

    s = 1'b1;
    tick();
    exp = '0; exp.o2 = 64'hA5; exp.o2v = 1'b1;
    checkAll("a5_o2", got8(), exp);

    // reset between edges clears immediately and holds
    #2 rst_n = 1'b0;
    #1 checkAll("rstMid", got8(), zero);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkAll($sformatf("rstHold%0d", k), got8(), zero);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h3C);
    rst_n = 1'b1;
    tick();
    exp = '0; exp.o1 = 64'h3C; exp.o1v = 1'b1;
    checkAll("rel3c", got8(), exp);

    // disabled: everything zero while s toggles
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, k[0], 1'b1, 8'hFF);
      tick();
      checkAll($sformatf("dis%0d", k), got8(), zero);
    end

    // data steered even without valid
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
    tick();
    exp = '0; exp.o2 = 64'h5A;
    checkAll("novalid", got8(), exp);

    // random traffic on the 16-bit instance and the combinational instance
    for (int n = 0; n < 1000; n++) begin
      outs_t expC;
      en  = ($urandom_range(0, 3) != 0);
      s   = $urandom_range(0, 1);
      v   = $urandom_range(0, 1);
      i16 = 16'($urandom);
      i8  = 8'($urandom);
      cEn = $urandom_range(0, 1);
      cS  = $urandom_range(0, 1);
      cV  = $urandom_range(0, 1);
      cI  = $urandom_range(0, 1);
      exp  = steer(en, s, v, 64'(i16));
      expC = steer(cEn, cS, cV, 64'(cI));
      #1;
      if (n % 50 == 0) checkAll($sformatf("rc%0d", n), gotComb(), expC);
      @(posedge clk);
      #1;
      checkAll($sformatf("r%0d", n), got16(), exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1x2.md
# demux_1x2

Registered one-input, two-output demultiplexer. A data word presented on `i` is steered to `o1` when `s`=0 or to `o2` when `s`=1. The unselected output is driven to all-zeros. Used as a leaf routing element wherever a single producer feeds one of two consumers under a select line, with optional output registering for timing closure.

## Interface

- `WIDTH`, default 1: data width of `i`, `o1`, `o2`; legal range 1..64.
- `REGISTERED`, default 1:
  - 1 = outputs registered, 1-cycle latency.
  - 0 = purely combinational path; `clk`/`rst_n` are ignored.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  enable; when 0, both outputs are forced to zero.
- `i`  input  WIDTH  data in.
- `s`  input  1  select: 0 steers to `o1`, 1 steers to `o2`.
- `v`  input  1  input-valid qualifier.
- `o1`  output  WIDTH  channel-1 data.
- `o2`  output  WIDTH  channel-2 data.
- `o1_v`  output  1  channel-1 valid.
- `o2_v`  output  1  channel-2 valid.

One clock; reset is asynchronous and active-low.

## Operation

- Steering function, evaluated on the current inputs:
  - `en`=1, `s`=0: `o1`=`i`, `o2`=0, `o1_v`=`v`, `o2_v`=0.
  - `en`=1, `s`=1: `o2`=`i`, `o1`=0, `o2_v`=`v`, `o1_v`=0.
  - `en`=0: `o1`=`o2`=0 and `o1_v`=`o2_v`=0, regardless of `s`, `i` and `v`.
- Data is steered even when `v`=0. `v` only qualifies the valid flags; downstream logic must use the valids.
- The unselected output is always exactly zero. It never holds a stale value.
- `o1` and `o2` are never both non-zero in the same cycle. `o1_v` and `o2_v` are never both 1.
- No width conversion: data is passed bit-for-bit with no sign extension or truncation.
- X or Z on `s` is not a supported condition. Verification must drive `s` to a known value at all times.

## Timing

- `REGISTERED`=1:
  - Outputs update on the rising edge of `clk` from the inputs sampled at that edge; latency is 1 cycle.
  - `rst_n` low forces `o1`, `o2`, `o1_v`, `o2_v` to 0 immediately, without waiting for a clock edge.
  - The outputs stay at 0 while `rst_n` is low.
  - Reset release is synchronised by the first rising edge after `rst_n` goes high. That edge samples the inputs normally.
  - Reset asserted mid-stream discards the in-flight word; no recovery or replay.
  - A `s` change takes effect on the next edge. There is no glitch or overlap cycle: in the cycle after the edge, only the newly selected output carries data.
- `REGISTERED`=0:
  - Outputs are a combinational function of `en`, `s`, `i` and `v`, with zero latency.
  - There is no reset behaviour.
- Every input may change in every cycle; there is no throughput limit (one word per cycle).

## Test plan

- `REGISTERED`=0, `WIDTH`=1, `en`=1, `v`=1. Apply in order, 5 ns apart: `s`=0/`i`=1, `s`=1/`i`=1, `s`=0/`i`=0, `s`=1/`i`=0. Required (o1,o2) after each step: (1,0), (0,1), (0,0), (0,0).
- `REGISTERED`=1, `WIDTH`=8. Drive `i`=0xA5, `s`=0, `v`=1 at edge N. Required at N+1: `o1`=0xA5, `o1_v`=1, `o2`=0x00, `o2_v`=0. Then `s`=1 at edge N+1. Required at N+2: `o1`=0, `o2`=0xA5, `o2_v`=1.
- Assert `rst_n`=0 between edges while `o2`=0xA5. Required: all outputs 0 immediately and held at 0 through 3 clocks. After release with `s`=0, `i`=0x3C, the next edge gives `o1`=0x3C.
- `en`=0 with `i`=0xFF, `v`=1, `s` toggled every cycle. Required: all four outputs 0 in every cycle.
- `v`=0, `s`=1, `i`=0x5A. Required at the next edge: `o2`=0x5A, `o2_v`=0, `o1`=0, `o1_v`=0.
- Random stimulus for 1000 cycles at `WIDTH`=16 against a one-cycle-delayed reference model. Required: exact match every cycle, and `o1_v`&`o2_v` never 1 together.
